// File: rtl/acc_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU; drives memory, IR/MDR/ACC and PC-write controls.
// Optional subroutine support (JSR/RTS) is compiled in when CTRL_SUBROUTINE_EN is defined.
module acc_control_fsm #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_src,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       acc_write,
  output logic       acc_src,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] pc_write_sig,
  output logic [3:0] branch_en,
  output logic       pc_write_cond,
  output logic       saved_pc_write,
  output logic       halted,
  output logic       illegal,
  output logic       bus_error
);

  typedef enum logic [2:0] {
    FETCH, DECODE, MEM, EXEC, BRANCH, JSR, RTS, HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t     state, nextState;
  logic [7:0] waitCnt;
  logic       memPhase;
  logic       timeout;
  logic       setIllegal;

  assign memPhase = (state == FETCH) || (state == MEM);
  // Timeout fires on the WAIT_LIMIT-th consecutive stalled cycle of one access.
  assign timeout  = (WAIT_LIMIT != 0) && memPhase && !mem_ready && (waitCnt == WAIT_LAST);

  always_comb begin
    nextState      = state;
    setIllegal     = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    addr_src       = 1'b0;
    ir_write       = 1'b0;
    mdr_write      = 1'b0;
    acc_write      = 1'b0;
    acc_src        = 1'b0;
    alu_op         = 3'd0;
    pc_src         = 2'd0;
    pc_write_sig   = 4'b0000;
    branch_en      = 4'b0000;
    pc_write_cond  = 1'b0;
    saved_pc_write = 1'b0;
    halted         = 1'b0;

    case (state)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          nextState = DECODE;
        end else if (timeout) begin
          nextState = HALT;
        end
      end
      DECODE: begin
        pc_write_sig = 4'b0011;
        case (opcode)
          OP_NOP:                               nextState = FETCH;
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6:   nextState = MEM;
          4'h7:                                 nextState = EXEC;
          4'h8, 4'h9, 4'hA, 4'hB, 4'hC:         nextState = BRANCH;
`ifdef CTRL_SUBROUTINE_EN
          4'hD:                                 nextState = JSR;
          4'hE:                                 nextState = RTS;
`else
          4'hD, 4'hE: begin
            nextState  = HALT;
            setIllegal = 1'b1;
          end
`endif
          default:                              nextState = HALT;
        endcase
      end
      MEM: begin
        addr_src = 1'b1;
        if (opcode == OP_STA) mem_write = 1'b1;
        else                  mem_read  = 1'b1;
        if (mem_ready) begin
          if (opcode == OP_STA) begin
            nextState = FETCH;
          end else begin
            mdr_write = 1'b1;
            nextState = EXEC;
          end
        end else if (timeout) begin
          nextState = HALT;
        end
      end
      EXEC: begin
        acc_write = 1'b1;
        if (opcode == OP_LDA) acc_src = 1'b1;
        else                  alu_op  = 3'(opcode - 4'd2);
        nextState = FETCH;
      end
      BRANCH: begin
        pc_src = 2'd1;
        if (opcode == OP_JMP) begin
          pc_write_sig = 4'b0011;
        end else begin
          pc_write_cond = 1'b1;
          case (opcode)
            4'h9:    branch_en = 4'b1000;
            4'hA:    branch_en = 4'b0010;
            4'hB:    branch_en = 4'b0100;
            4'hC:    branch_en = 4'b0001;
            default: branch_en = 4'b0000;
          endcase
        end
        nextState = FETCH;
      end
`ifdef CTRL_SUBROUTINE_EN
      JSR: begin
        saved_pc_write = 1'b1;
        pc_src         = 2'd1;
        pc_write_sig   = 4'b0011;
        nextState      = FETCH;
      end
      RTS: begin
        pc_src       = 2'd2;
        pc_write_sig = 4'b1001;
        nextState    = FETCH;
      end
`endif
      HALT: begin
        halted    = 1'b1;
        nextState = HALT;
      end
      default: nextState = FETCH;
    endcase

    // No architectural state may change in a reset cycle.
    if (reset) begin
      mem_write      = 1'b0;
      ir_write       = 1'b0;
      mdr_write      = 1'b0;
      acc_write      = 1'b0;
      pc_write_sig   = 4'b0000;
      pc_write_cond  = 1'b0;
      saved_pc_write = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FETCH;
      waitCnt   <= 8'd0;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state <= nextState;
      if (nextState != state)          waitCnt <= 8'd0;
      else if (memPhase && !mem_ready) waitCnt <= waitCnt + 8'd1;
      if (setIllegal) illegal   <= 1'b1;
      if (timeout)    bus_error <= 1'b1;
    end
  end

endmodule
